// File: rtl/rr_cs_arbiter8_pkg.sv
// Shared types and constants for the 8-way round-robin chip-select arbiter.
package rr_cs_arbiter8_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned SEL_W   = 3;

  localparam logic [NUM_REQ-1:0] SEL_OFF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Active-low one-hot decode of the shared chip-select decoder.
  function automatic logic [NUM_REQ-1:0] decode_gnt(input logic               enb_n,
                                                    input logic [SEL_W-1:0] sel);
    logic [NUM_REQ-1:0] one;
    one = NUM_REQ'(1);
    return enb_n ? SEL_OFF : ~(one << sel);
  endfunction

endpackage

// File: rtl/rr_cs_arbiter8_pick.sv
// Combinational round-robin picker: first low request after the last winner, with wrap.
module rr_pick8
  import rr_cs_arbiter8_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_n_i,
  input  logic [SEL_W-1:0]   last_i,
  output logic [SEL_W-1:0]   win_c_o,
  output logic               valid_c_o
);

  logic [SEL_W-1:0] idx;

  // Offset 1 is highest priority; offset NUM_REQ wraps back onto the last winner.
  always_comb begin
    win_c_o   = '0;
    valid_c_o = 1'b0;
    idx       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = last_i + SEL_W'(k);
      if (!valid_c_o && !req_n_i[idx]) begin
        win_c_o   = idx;
        valid_c_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_cs_arbiter8.sv
// Round-robin arbiter driving a shared 8-way active-low chip-select decoder,
// with a bounded hold time per grant and a dead-time gap between grants.
module rr_cs_arbiter8
  import rr_cs_arbiter8_pkg::*;
#(
  parameter int unsigned MAX_HOLD   = 16,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned CNT_W      = 5
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic [NUM_REQ-1:0] req_,
  output logic [SEL_W-1:0]   sel,
  output logic               enb_,
  output logic [NUM_REQ-1:0] gnt_,
  output logic               busy,
  output logic               timeout
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             enb_q, enb_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic [SEL_W-1:0] pick_win;
  logic             pick_valid;

  rr_pick8 u_pick (
    .req_n_i   (req_),
    .last_i    (last_q),
    .win_c_o   (pick_win),
    .valid_c_o (pick_valid)
  );

  // Next-state and registered-output logic; one counter serves hold and gap timing.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    sel_d     = sel_q;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          sel_d   = pick_win;
          last_d  = pick_win;
          cnt_d   = CNT_ONE;
        end
      end
      GRANT: begin
        if (req_[sel_q]) begin
          state_d = GAP;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == HOLD_LIM) begin
          state_d   = GAP;
          cnt_d     = CNT_ONE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LIM) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    enb_d  = (state_d != GRANT);
    busy_d = (state_d != IDLE);
  end

  // Async reset forces the decoder off immediately, abandoning any grant.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= SEL_W'(NUM_REQ - 1);
      sel_q     <= '0;
      enb_q     <= 1'b1;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      enb_q     <= enb_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign sel     = sel_q;
  assign enb_    = enb_q;
  assign gnt_    = decode_gnt(enb_q, sel_q);
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_cs_arbiter8.sv
// Scoreboard bench for rr_cs_arbiter8: expected grants are queued by the stimulus
// and checked by a monitor as each grant starts and ends.
module tb_rr_cs_arbiter8;

  localparam int unsigned MH    = 4;
  localparam int unsigned GAP_A = 1;
  localparam int unsigned GAP_B = 3;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] gnt;
    int         hold;   // 0 = do not check
    logic       to;
    int         gap;    // dead cycles before this grant, 0 = do not check
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_  = 1'b0;
  logic [7:0] req_a = 8'hFF;
  logic [7:0] req_b = 8'hFF;

  logic [2:0] sel_a, sel_b;
  logic       enb_a, enb_b;
  logic [7:0] gnt_a, gnt_b;
  logic       busy_a, busy_b, to_a, to_b;

  int tests = 0;
  int fails = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  rr_cs_arbiter8 #(.MAX_HOLD(MH), .GAP_CYCLES(GAP_A), .CNT_W(5)) u_dut_a (
    .clk(clk), .rst_(rst_), .req_(req_a), .sel(sel_a), .enb_(enb_a),
    .gnt_(gnt_a), .busy(busy_a), .timeout(to_a)
  );

  rr_cs_arbiter8 #(.MAX_HOLD(MH), .GAP_CYCLES(GAP_B), .CNT_W(5)) u_dut_b (
    .clk(clk), .rst_(rst_), .req_(req_b), .sel(sel_b), .enb_(enb_b),
    .gnt_(gnt_b), .busy(busy_b), .timeout(to_b)
  );

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  task automatic push(input int d, input logic [2:0] s, input logic [7:0] g,
                      input int h, input logic to, input int gap);
    exp_t e;
    e.sel = s; e.gnt = g; e.hold = h; e.to = to; e.gap = gap;
    if (d == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  task automatic wait_enb(input int d, input logic v);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (((d == 0) ? enb_a : enb_b) === v) return;
    end
    tests++;
    fails++;
    $display("FAIL wait_enb dut%0d: enb_ never reached %0b", d, v);
  endtask

  // Monitor state, one slot per DUT
  logic       in_g [2] = '{1'b0, 1'b0};
  int         hold_n [2] = '{0, 0};
  int         dead_n [2] = '{0, 0};
  int         busy_n [2] = '{0, 0};
  logic       bad_g [2] = '{1'b0, 1'b0};
  logic       bad_d [2] = '{1'b0, 1'b0};
  exp_t       cur [2];
  logic [2:0] m_sel;
  logic       m_enb, m_busy, m_to;
  logic [7:0] m_gnt;
  int         m_gap;

  always @(negedge clk) begin
    if ($isunknown(req_a) || $isunknown(req_b)) begin
      fails++;
      $display("FAIL req_x: req_a=%b req_b=%b at %0t", req_a, req_b, $time);
    end
    for (int d = 0; d < 2; d++) begin
      m_sel  = (d == 0) ? sel_a  : sel_b;
      m_enb  = (d == 0) ? enb_a  : enb_b;
      m_gnt  = (d == 0) ? gnt_a  : gnt_b;
      m_busy = (d == 0) ? busy_a : busy_b;
      m_to   = (d == 0) ? to_a   : to_b;
      m_gap  = (d == 0) ? GAP_A  : GAP_B;
      if (!rst_) begin
        chk("rst_enb",  d, 32'(m_enb),  32'd1);
        chk("rst_gnt",  d, 32'(m_gnt),  32'hFF);
        chk("rst_busy", d, 32'(m_busy), 32'd0);
        chk("rst_to",   d, 32'(m_to),   32'd0);
        chk("rst_sel",  d, 32'(m_sel),  32'd0);
        in_g[d] = 1'b0; dead_n[d] = 0; busy_n[d] = 0; bad_d[d] = 1'b0;
      end else if (m_enb === 1'b0) begin
        if (!in_g[d]) begin
          if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
            tests++;
            fails++;
            $display("FAIL unexpected_grant dut%0d: sel=%0d gnt=%h at %0t", d, m_sel, m_gnt, $time);
            cur[d].sel = m_sel; cur[d].gnt = m_gnt; cur[d].hold = 0; cur[d].to = 1'b0; cur[d].gap = 0;
          end else if (d == 0) begin
            cur[d] = q_a.pop_front();
          end else begin
            cur[d] = q_b.pop_front();
          end
          chk("grant_sel",  d, 32'(m_sel),  32'(cur[d].sel));
          chk("grant_gnt",  d, 32'(m_gnt),  32'(cur[d].gnt));
          chk("grant_busy", d, 32'(m_busy), 32'd1);
          if (cur[d].gap != 0) begin
            chk("dead_cycles", d, 32'(dead_n[d]), 32'(cur[d].gap));
            chk("gap_busy",    d, 32'(busy_n[d]), 32'(m_gap));
            chk("dead_clean",  d, 32'(bad_d[d]),  32'd0);
          end
          in_g[d] = 1'b1; hold_n[d] = 1; bad_g[d] = (m_to !== 1'b0);
        end else begin
          hold_n[d]++;
          if (m_gnt !== cur[d].gnt || m_sel !== cur[d].sel || m_busy !== 1'b1 || m_to !== 1'b0)
            bad_g[d] = 1'b1;
        end
      end else begin
        if (in_g[d]) begin
          if (cur[d].hold != 0) chk("hold_cycles", d, 32'(hold_n[d]), 32'(cur[d].hold));
          chk("timeout_pulse", d, 32'(m_to),     32'(cur[d].to));
          chk("grant_stable",  d, 32'(bad_g[d]), 32'd0);
          chk("release_gnt",   d, 32'(m_gnt),    32'hFF);
          chk("release_busy",  d, 32'(m_busy),   32'd1);
          in_g[d] = 1'b0; dead_n[d] = 1; busy_n[d] = int'(m_busy); bad_d[d] = 1'b0;
        end else begin
          dead_n[d]++;
          busy_n[d] += int'(m_busy);
          if (m_gnt !== 8'hFF || m_to !== 1'b0) bad_d[d] = 1'b1;
        end
      end
    end
  end

  // Reset must kill the decoder before the next clock edge.
  always @(negedge rst_) begin
    #1;
    chk("async_rst_gnt", 0, 32'(gnt_a), 32'hFF);
    chk("async_rst_enb", 0, 32'(enb_a), 32'd1);
    chk("async_rst_gnt", 1, 32'(gnt_b), 32'hFF);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    logic [7:0] one;
    one = 8'h01;

    rst_ = 1'b0; req_a = 8'h00; req_b = 8'h00;
    repeat (3) @(negedge clk);
    req_a = 8'hFF; req_b = 8'hFF;
    @(negedge clk);
    rst_ = 1'b1;
    repeat (2) @(negedge clk);

    // Round robin: everyone requests, each grant released after two cycles
    for (int i = 0; i < 9; i++)
      push(0, 3'(i % 8), ~(one << (i % 8)), 2, 1'b0, (i == 0) ? 0 : 2);
    req_a = 8'h00;
    for (int i = 0; i < 9; i++) begin
      b = i % 8;
      wait_enb(0, 1'b0);
      @(negedge clk);
      req_a[b] = 1'b1;
      @(negedge clk);
      req_a = (i == 8) ? 8'hFF : 8'h00;
    end

    // Single requester 2 for three cycles
    repeat (3) @(negedge clk);
    push(0, 3'd2, 8'hFB, 3, 1'b0, 0);
    req_a = 8'hFB;
    repeat (3) @(negedge clk);
    req_a = 8'hFF;

    // Release on the same edge the hold limit expires: no timeout
    repeat (3) @(negedge clk);
    push(0, 3'd4, 8'hEF, 4, 1'b0, 0);
    req_a = 8'hEF;
    wait_enb(0, 1'b0);
    repeat (3) @(negedge clk);
    req_a = 8'hFF;

    // Timeout and regrant of 7, then fairness with 0 also requesting
    repeat (3) @(negedge clk);
    push(0, 3'd7, 8'h7F, 4, 1'b1, 0);
    push(0, 3'd7, 8'h7F, 4, 1'b1, 2);
    req_a = 8'h7F;
    wait_enb(0, 1'b0);
    wait_enb(0, 1'b1);
    wait_enb(0, 1'b0);
    push(0, 3'd0, 8'hFE, 4, 1'b1, 2);
    push(0, 3'd7, 8'h7F, 2, 1'b0, 2);
    req_a = 8'h7E;
    wait_enb(0, 1'b1);
    wait_enb(0, 1'b0);
    wait_enb(0, 1'b1);
    wait_enb(0, 1'b0);
    @(negedge clk);
    req_a = 8'hFF;

    // Reset in the middle of a grant
    repeat (4) @(negedge clk);
    push(0, 3'd5, 8'hDF, 0, 1'b0, 0);
    req_a = 8'hDF;
    wait_enb(0, 1'b0);
    #2 rst_ = 1'b0;
    @(negedge clk);
    req_a = 8'hFF;
    @(negedge clk);
    rst_ = 1'b1;

    // Three-cycle gap: requesters 0 and 1 both hold until timeout
    repeat (3) @(negedge clk);
    push(1, 3'd0, 8'hFE, 4, 1'b1, 0);
    push(1, 3'd1, 8'hFD, 4, 1'b1, 4);
    push(1, 3'd0, 8'hFE, 4, 1'b1, 4);
    req_b = 8'hFC;
    wait_enb(1, 1'b0);
    wait_enb(1, 1'b1);
    wait_enb(1, 1'b0);
    wait_enb(1, 1'b1);
    wait_enb(1, 1'b0);
    wait_enb(1, 1'b1);
    req_b = 8'hFF;
    repeat (8) @(negedge clk);

    chk("queue_empty", 0, 32'(q_a.size()), 32'd0);
    chk("queue_empty", 1, 32'(q_b.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
